// File: rtl/enc_pkg.sv
// enc_pkg: shared types and constants for the RV32IM instruction encoder.
// Holds the op enum, word formats, opcode/funct constants and the NOP word.
package enc_pkg;

    localparam int OP_W = 6;

    // Request op codes; any value past OP_LI is an unknown op.
    typedef enum logic [OP_W-1:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
        OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI,
        OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE,
        OP_BLTU, OP_BGEU,
        OP_JAL, OP_JALR, OP_LUI, OP_AUIPC,
        OP_ECALL, OP_EBREAK,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
        OP_DIV, OP_DIVU, OP_REM, OP_REMU,
        OP_LI
    } op_e;

    typedef enum logic [3:0] {
        FMT_BAD, FMT_R, FMT_I, FMT_SH,
        FMT_S, FMT_B, FMT_U, FMT_J, FMT_SYS
    } fmt_e;

    typedef enum logic {
        ST_IDLE,
        ST_LI_LO
    } state_e;

    typedef struct packed {
        logic [31:0] word;
        logic        err;
    } pack_t;

    localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0013;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MD   = 7'b0000001;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_B    = 3'b000;
    localparam logic [2:0] F3_H    = 3'b001;
    localparam logic [2:0] F3_W    = 3'b010;
    localparam logic [2:0] F3_BU   = 3'b100;
    localparam logic [2:0] F3_HU   = 3'b101;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // True when v is the sign extension of v[msb:0].
    function automatic logic sx_fits(
        input logic [31:0] v,
        input int          msb
    );
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i >= msb && v[i] != v[31]) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request and instruction-word valid/ready bundle.
// slave = encoder view, master = producer/consumer view.
interface instr_encoder_if;
    import enc_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [OP_W-1:0] in_op;
    logic [4:0]      in_rd;
    logic [4:0]      in_rs1;
    logic [4:0]      in_rs2;
    logic [31:0]     in_imm;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic            out_last;
    logic            out_err;

    modport slave (
        input  in_valid, in_op, in_rd,
        input  in_rs1, in_rs2, in_imm,
        input  out_ready,
        output in_ready,
        output out_valid, out_instr,
        output out_last, out_err
    );

    modport master (
        output in_valid, in_op, in_rd,
        output in_rs1, in_rs2, in_imm,
        output out_ready,
        input  in_ready,
        input  out_valid, out_instr,
        input  out_last, out_err
    );

endinterface

// File: rtl/instr_pack.sv
// instr_pack: combinational op + fields -> {32-bit word, err}.
// Ports: op_i, rd_i, rs1_i, rs2_i, imm_i in; res_o {word, err} out.
// RV32M_EN defined adds MUL..REMU; otherwise they encode as unknown ops.
module instr_pack
    import enc_pkg::*;
#(
    parameter logic [31:0] NOP_WORD  = NOP_WORD_DEF,
    parameter int          RANGE_CHK = 1
) (
    input  logic [OP_W-1:0] op_i,
    input  logic [4:0]      rd_i,
    input  logic [4:0]      rs1_i,
    input  logic [4:0]      rs2_i,
    input  logic [31:0]     imm_i,
    output pack_t           res_o
);

    fmt_e       fmt;
    logic [6:0] opc;
    logic [6:0] f7;
    logic [2:0] f3;
    logic       ebrk;
    logic       rng;
    logic [31:0] word;

    always_comb begin
        fmt  = FMT_BAD;
        opc  = OPC_OP;
        f7   = F7_BASE;
        f3   = 3'b000;
        ebrk = 1'b0;
        unique case (op_i)
            OP_ADD:   begin fmt = FMT_R; f3 = F3_ADD; end
            OP_SUB:   begin fmt = FMT_R; f3 = F3_ADD; f7 = F7_ALT; end
            OP_SLL:   begin fmt = FMT_R; f3 = F3_SLL; end
            OP_SLT:   begin fmt = FMT_R; f3 = F3_SLT; end
            OP_SLTU:  begin fmt = FMT_R; f3 = F3_SLTU; end
            OP_XOR:   begin fmt = FMT_R; f3 = F3_XOR; end
            OP_SRL:   begin fmt = FMT_R; f3 = F3_SR; end
            OP_SRA:   begin fmt = FMT_R; f3 = F3_SR; f7 = F7_ALT; end
            OP_OR:    begin fmt = FMT_R; f3 = F3_OR; end
            OP_AND:   begin fmt = FMT_R; f3 = F3_AND; end
            OP_ADDI:  begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = F3_ADD; end
            OP_SLTI:  begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = F3_SLT; end
            OP_SLTIU: begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = F3_SLTU; end
            OP_XORI:  begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = F3_XOR; end
            OP_ORI:   begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = F3_OR; end
            OP_ANDI:  begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = F3_AND; end
            OP_SLLI:  begin fmt = FMT_SH; opc = OPC_OP_IMM; f3 = F3_SLL; end
            OP_SRLI:  begin fmt = FMT_SH; opc = OPC_OP_IMM; f3 = F3_SR; end
            OP_SRAI:  begin
                fmt = FMT_SH; opc = OPC_OP_IMM; f3 = F3_SR; f7 = F7_ALT;
            end
            OP_LB:    begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_B; end
            OP_LH:    begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_H; end
            OP_LW:    begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_W; end
            OP_LBU:   begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_BU; end
            OP_LHU:   begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_HU; end
            OP_SB:    begin fmt = FMT_S; opc = OPC_STORE; f3 = F3_B; end
            OP_SH:    begin fmt = FMT_S; opc = OPC_STORE; f3 = F3_H; end
            OP_SW:    begin fmt = FMT_S; opc = OPC_STORE; f3 = F3_W; end
            OP_BEQ:   begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BEQ; end
            OP_BNE:   begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BNE; end
            OP_BLT:   begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BLT; end
            OP_BGE:   begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BGE; end
            OP_BLTU:  begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BLTU; end
            OP_BGEU:  begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BGEU; end
            OP_JAL:   begin fmt = FMT_J; opc = OPC_JAL; end
            OP_JALR:  begin fmt = FMT_I; opc = OPC_JALR; end
            OP_LUI:   begin fmt = FMT_U; opc = OPC_LUI; end
            OP_AUIPC: begin fmt = FMT_U; opc = OPC_AUIPC; end
            OP_ECALL: begin fmt = FMT_SYS; opc = OPC_SYSTEM; end
            OP_EBREAK: begin
                fmt = FMT_SYS; opc = OPC_SYSTEM; ebrk = 1'b1;
            end
`ifdef RV32M_EN
            OP_MUL:    begin fmt = FMT_R; f7 = F7_MD; f3 = F3_MUL; end
            OP_MULH:   begin fmt = FMT_R; f7 = F7_MD; f3 = F3_MULH; end
            OP_MULHSU: begin fmt = FMT_R; f7 = F7_MD; f3 = F3_MULHSU; end
            OP_MULHU:  begin fmt = FMT_R; f7 = F7_MD; f3 = F3_MULHU; end
            OP_DIV:    begin fmt = FMT_R; f7 = F7_MD; f3 = F3_DIV; end
            OP_DIVU:   begin fmt = FMT_R; f7 = F7_MD; f3 = F3_DIVU; end
            OP_REM:    begin fmt = FMT_R; f7 = F7_MD; f3 = F3_REM; end
            OP_REMU:   begin fmt = FMT_R; f7 = F7_MD; f3 = F3_REMU; end
`endif
            default:  fmt = FMT_BAD;
        endcase
    end

    // Only the fields a format uses reach the word; the rest are zero.
    always_comb begin
        word = NOP_WORD;
        rng  = 1'b0;
        unique case (fmt)
            FMT_R: word = {f7, rs2_i, rs1_i, f3, rd_i, opc};
            FMT_I: begin
                word = {imm_i[11:0], rs1_i, f3, rd_i, opc};
                rng  = !sx_fits(imm_i, 11);
            end
            FMT_SH: begin
                word = {f7, imm_i[4:0], rs1_i, f3, rd_i, opc};
                rng  = |imm_i[31:5];
            end
            FMT_S: begin
                word = {imm_i[11:5], rs2_i, rs1_i, f3,
                        imm_i[4:0], opc};
                rng  = !sx_fits(imm_i, 11);
            end
            FMT_B: begin
                word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, f3,
                        imm_i[4:1], imm_i[11], opc};
                rng  = !sx_fits(imm_i, 12) || imm_i[0];
            end
            FMT_U: word = {imm_i[31:12], rd_i, opc};
            FMT_J: begin
                word = {imm_i[20], imm_i[10:1], imm_i[11],
                        imm_i[19:12], rd_i, opc};
                rng  = !sx_fits(imm_i, 20) || imm_i[0];
            end
            FMT_SYS: word = {11'd0, ebrk, 13'd0, opc};
            default: word = NOP_WORD;
        endcase
    end

    assign res_o.word = word;
    assign res_o.err  = (fmt == FMT_BAD) ||
                        ((RANGE_CHK != 0) && rng);

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: RV32IM request -> instruction word, one registered stage.
// Ports: clk, rst_n (async, active low), bus (slave: in_* request, out_* word).
// LI expands to LUI+ADDI through a two-state FSM. RV32M_EN enables M ops.
module instr_encoder
    import enc_pkg::*;
#(
    parameter logic [31:0] NOP_WORD  = NOP_WORD_DEF,
    parameter int          RANGE_CHK = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    instr_encoder_if.slave  bus
);

    state_e      state_q, state_d;
    logic        out_valid_q;
    logic [31:0] out_instr_q, instr_d;
    logic        out_last_q, last_d;
    logic        out_err_q, err_d;
    logic [4:0]  li_rd_q, li_rd_d;
    logic [11:0] li_lo_q, li_lo_d;

    logic        slot_free;
    logic        accept;
    logic        load;
    logic        li_nop;
    logic [31:0] li_sum;

    logic [OP_W-1:0] p_op;
    logic [4:0]      p_rd, p_rs1, p_rs2;
    logic [31:0]     p_imm;
    pack_t           pk;

    assign slot_free = !out_valid_q || bus.out_ready;
    assign bus.in_ready = rst_n && (state_q == ST_IDLE) && slot_free;
    assign accept = bus.in_valid && bus.in_ready;
    assign load = accept || ((state_q == ST_LI_LO) && slot_free);

    // Rounded upper part: ADDI sign-extends the low 12 bits.
    assign li_sum = bus.in_imm + 32'h0000_0800;

    always_comb begin
        p_op    = bus.in_op;
        p_rd    = bus.in_rd;
        p_rs1   = bus.in_rs1;
        p_rs2   = bus.in_rs2;
        p_imm   = bus.in_imm;
        li_nop  = 1'b0;
        last_d  = 1'b1;
        state_d = ST_IDLE;
        li_rd_d = li_rd_q;
        li_lo_d = li_lo_q;
        if (state_q == ST_LI_LO) begin
            p_op  = OP_ADDI;
            p_rd  = li_rd_q;
            p_rs1 = li_rd_q;
            p_rs2 = '0;
            p_imm = {{20{li_lo_q[11]}}, li_lo_q};
        end else if (bus.in_op == OP_LI) begin
            p_rs1 = '0;
            p_rs2 = '0;
            if (bus.in_rd == 5'd0) begin
                li_nop = 1'b1;
            end else if (sx_fits(bus.in_imm, 11)) begin
                p_op = OP_ADDI;
            end else begin
                p_op  = OP_LUI;
                p_imm = {li_sum[31:12], 12'h000};
                if (bus.in_imm[11:0] != 12'h000) begin
                    last_d  = 1'b0;
                    state_d = ST_LI_LO;
                    li_rd_d = bus.in_rd;
                    li_lo_d = bus.in_imm[11:0];
                end
            end
        end
        instr_d = li_nop ? NOP_WORD : pk.word;
        err_d   = li_nop ? 1'b0 : pk.err;
    end

    instr_pack #(
        .NOP_WORD  (NOP_WORD),
        .RANGE_CHK (RANGE_CHK)
    ) u_pack (
        .op_i  (p_op),
        .rd_i  (p_rd),
        .rs1_i (p_rs1),
        .rs2_i (p_rs2),
        .imm_i (p_imm),
        .res_o (pk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_last_q  <= 1'b0;
            out_err_q   <= 1'b0;
            li_rd_q     <= '0;
            li_lo_q     <= '0;
        end else if (load) begin
            state_q     <= state_d;
            out_valid_q <= 1'b1;
            out_instr_q <= instr_d;
            out_last_q  <= last_d;
            out_err_q   <= err_d;
            li_rd_q     <= li_rd_d;
            li_lo_q     <= li_lo_d;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: vector table plus hand sequences for instr_encoder.
// Expected words are queued at accept and compared on output transfer.
module tb_instr_encoder;
    import enc_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        last;
        logic        err;
    } exp_t;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        exp_t        e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_encoder_if bus();

    instr_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t exp_q[$];
    vec_t vecs[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input string n, input logic [31:0] w,
                                input logic l, input logic e);
        exp_t x;
        x.name = n; x.instr = w; x.last = l; x.err = e;
        return x;
    endfunction

    task automatic addv(input string n, input logic [5:0] op,
                        input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm,
                        input logic [31:0] w, input logic l,
                        input logic e);
        vec_t v;
        v.name = n; v.op = op; v.rd = rd; v.rs1 = rs1;
        v.rs2 = rs2; v.imm = imm; v.e = mk(n, w, l, e);
        vecs.push_back(v);
    endtask

    // Transfer happens at the next posedge; out_* are stable here.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got 0x%08h want none",
                         bus.out_instr);
            end else begin
                mon_e = exp_q.pop_front();
                chk({mon_e.name, ".instr"}, bus.out_instr, mon_e.instr);
                chk({mon_e.name, ".last"}, {31'd0, bus.out_last},
                    {31'd0, mon_e.last});
                chk({mon_e.name, ".err"}, {31'd0, bus.out_err},
                    {31'd0, mon_e.err});
            end
        end
    end

    task automatic send(input string n, input logic [5:0] op,
                        input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm,
                        input bit push, input exp_t e);
        int t;
        t = 0;
        @(negedge clk);
        bus.in_op = op; bus.in_rd = rd; bus.in_rs1 = rs1;
        bus.in_rs2 = rs2; bus.in_imm = imm; bus.in_valid = 1'b1;
        #1;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s.accept: got in_ready=0 want 1 within 50",
                     n);
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            if (push) exp_q.push_back(e);
            #1;
            bus.in_valid = 1'b0;
            chk({n, ".lat"}, {31'd0, bus.out_valid}, 32'd1);
        end
    endtask

    task automatic drain(input string n);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk({n, ".drain"}, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        exp_t e2;
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_rd = '0;
        bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_imm = '0;
        bus.out_ready = 1'b1;

        addv("add", OP_ADD, 3, 1, 2, 0, 32'h002081B3, 1, 0);
        addv("sub", OP_SUB, 3, 1, 2, 0, 32'h402081B3, 1, 0);
        addv("addi5", OP_ADDI, 1, 0, 0, 5, 32'h00500093, 1, 0);
        addv("addim1", OP_ADDI, 1, 2, 0, 32'hFFFFFFFF,
             32'hFFF10093, 1, 0);
        addv("addi2048", OP_ADDI, 1, 0, 0, 32'd2048,
             32'h80000093, 1, 1);
        addv("addim2048", OP_ADDI, 1, 0, 0, 32'hFFFFF800,
             32'h80000093, 1, 0);
        addv("srai", OP_SRAI, 1, 2, 0, 3, 32'h40315093, 1, 0);
        addv("slli32", OP_SLLI, 1, 2, 0, 32, 32'h00011093, 1, 1);
        addv("sw", OP_SW, 0, 2, 3, 8, 32'h00312423, 1, 0);
        addv("lw", OP_LW, 5, 2, 0, 32'hFFFFFFFC, 32'hFFC12283, 1, 0);
        addv("beq8", OP_BEQ, 0, 1, 2, 8, 32'h00208463, 1, 0);
        addv("beq3", OP_BEQ, 0, 1, 2, 3, 32'h00208163, 1, 1);
        addv("bnem4096", OP_BNE, 0, 1, 2, 32'hFFFFF000,
             32'h80209063, 1, 0);
        addv("bne4096", OP_BNE, 0, 1, 2, 32'd4096,
             32'h80209063, 1, 1);
        addv("jal2048", OP_JAL, 1, 0, 0, 32'd2048, 32'h001000EF, 1, 0);
        addv("jal1m", OP_JAL, 1, 0, 0, 32'h00100000,
             32'h800000EF, 1, 1);
        addv("jalr", OP_JALR, 1, 5, 0, 0, 32'h000280E7, 1, 0);
        addv("lui", OP_LUI, 5, 7, 7, 32'h12345000, 32'h123452B7, 1, 0);
        addv("auipc", OP_AUIPC, 1, 0, 0, 32'h1000, 32'h00001097, 1, 0);
        addv("ecall", OP_ECALL, 0, 0, 0, 0, 32'h00000073, 1, 0);
        addv("unknown", 6'd60, 3, 1, 2, 0, 32'h00000013, 1, 1);
`ifdef RV32M_EN
        addv("mul", OP_MUL, 3, 1, 2, 0, 32'h022081B3, 1, 0);
`else
        addv("mul", OP_MUL, 3, 1, 2, 0, 32'h00000013, 1, 1);
`endif
        addv("li_m5", OP_LI, 2, 0, 0, 32'hFFFFFFFB, 32'hFFB00113, 1, 0);
        addv("li_2047", OP_LI, 1, 0, 0, 32'd2047, 32'h7FF00093, 1, 0);
        addv("li_x0", OP_LI, 0, 0, 0, 32'h12345678, 32'h00000013, 1, 0);
        addv("li_3000", OP_LI, 1, 0, 0, 32'h3000, 32'h000030B7, 1, 0);

        #12;
        chk("rst.valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst.instr", bus.out_instr, 32'd0);
        chk("rst.last", {31'd0, bus.out_last}, 32'd0);
        chk("rst.err", {31'd0, bus.out_err}, 32'd0);
        chk("rst.in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            send(vecs[i].name, vecs[i].op, vecs[i].rd, vecs[i].rs1,
                 vecs[i].rs2, vecs[i].imm, 1'b1, vecs[i].e);
        end
        drain("table");

        send("li_big", OP_LI, 5, 0, 0, 32'h12345678, 1'b1,
             mk("li_big.hi", 32'h123452B7, 0, 0));
        exp_q.push_back(mk("li_big.lo", 32'h67828293, 1, 0));
        chk("li_big.busy", {31'd0, bus.in_ready}, 32'd0);
        drain("li_big");

        send("li_800", OP_LI, 1, 0, 0, 32'h800, 1'b1,
             mk("li_800.hi", 32'h000010B7, 0, 0));
        exp_q.push_back(mk("li_800.lo", 32'h80008093, 1, 0));
        chk("li_800.busy", {31'd0, bus.in_ready}, 32'd0);
        drain("li_800");

        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        send("stall", OP_ADDI, 1, 0, 0, 5, 1'b1,
             mk("stall", 32'h00500093, 1, 0));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall.hold", bus.out_instr, 32'h00500093);
            chk("stall.valid", {31'd0, bus.out_valid}, 32'd1);
            chk("stall.in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        drain("stall");

        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        e2 = mk("rst_li", 32'h0, 0, 0);
        send("rst_li", OP_LI, 5, 0, 0, 32'h12345678, 1'b0, e2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_li.valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_li.instr", bus.out_instr, 32'd0);
        chk("rst_li.in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        send("post_rst", OP_ADD, 3, 1, 2, 0, 1'b1,
             mk("post_rst", 32'h002081B3, 1, 0));
        drain("post_rst");

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
